uart_tx_module: RTL and testbench

- Serial asynchronous (UART-style) transmitter.
- Takes an 8-bit parallel word and drives one 11-bit frame on a single line: start, 8 data bits LSB first, parity, stop.
- Sits between a byte producer and the serial pin. A downstream serial-in/parallel-out capture register on the same clock can reconstruct the frame.
- One bit per CLKS_PER_BIT clocks; the default of 1 gives one bit per clock.

---
 rtl/uart_tx_module.sv | 146 ++++++++++++++
 tb/tb_uart_tx_module.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_module.sv
// UART-style serial transmitter: start bit, DATA_W data bits LSB first, parity, stop.
// Each bit is held for CLKS_PER_BIT clocks; tx and busy come straight from flops.
module uart_tx_module #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] data_in,
    output logic              tx,
    output logic              busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    function automatic logic calc_parity(input logic [DATA_W-1:0] d);
        logic p;
        p = ^d;
        if (PARITY_ODD != 0) begin
            p = ~p;
        end else begin
            p = p;
        end
        return p;
    endfunction

    state_t            state_r;
    logic [DATA_W-1:0] shift_r;
    logic              parity_r;
    logic [CW-1:0]     clk_cnt_r;
    logic [BW-1:0]     bit_cnt_r;
    logic              tx_r;
    logic              busy_r;
    logic              bit_end_s;

    assign bit_end_s = (clk_cnt_r == CLK_LAST);
    assign tx        = tx_r;
    assign busy      = busy_r;

    // Frame sequencer: shift register already holds the next bit to send,
    // so the registered tx value is set on the edge that starts each bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            shift_r   <= '0;
            parity_r  <= 1'b0;
            clk_cnt_r <= '0;
            bit_cnt_r <= '0;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    clk_cnt_r <= '0;
                    bit_cnt_r <= '0;
                    if (enable) begin
                        shift_r  <= data_in;
                        parity_r <= calc_parity(data_in);
                        state_r  <= ST_START;
                        tx_r     <= 1'b0;
                        busy_r   <= 1'b1;
                    end else begin
                        tx_r   <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        clk_cnt_r <= '0;
                        bit_cnt_r <= '0;
                        tx_r      <= shift_r[0];
                        shift_r   <= shift_r >> 1;
                        state_r   <= ST_DATA;
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        clk_cnt_r <= '0;
                        if (bit_cnt_r == BIT_LAST) begin
                            bit_cnt_r <= '0;
                            tx_r      <= parity_r;
                            state_r   <= ST_PARITY;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BW'(1);
                            tx_r      <= shift_r[0];
                            shift_r   <= shift_r >> 1;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CW'(1);
                    end
                end
                ST_PARITY: begin
                    if (bit_end_s) begin
                        clk_cnt_r <= '0;
                        tx_r      <= 1'b1;
                        state_r   <= ST_STOP;
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CW'(1);
                    end
                end
                ST_STOP: begin
                    // End of stop: reload immediately for back-to-back frames
                    if (bit_end_s) begin
                        clk_cnt_r <= '0;
                        if (enable) begin
                            shift_r  <= data_in;
                            parity_r <= calc_parity(data_in);
                            state_r  <= ST_START;
                            tx_r     <= 1'b0;
                            busy_r   <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            tx_r    <= 1'b1;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    clk_cnt_r <= '0;
                    bit_cnt_r <= '0;
                    tx_r      <= 1'b1;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_module.sv
// Scoreboard bench for uart_tx_module: even/odd parity and 4-clocks-per-bit instances.
// Stimulus pushes expected 11-bit frames {stop,parity,data,start}; a monitor rebuilds frames from tx.
module tb_uart_tx_module;

    logic       clk = 1'b0;
    logic       reset;
    logic       en0, en1, en2;
    logic [7:0] d0, d1, d2;
    logic       tx0, tx1, tx2;
    logic       busy0, busy1, busy2;

    int nvec  = 0;
    int nfail = 0;
    bit mon_on = 1'b0;

    logic [10:0] q0[$];
    logic [10:0] q1[$];
    logic [10:0] q2[$];

    int          cpb       [3] = '{1, 1, 4};
    int          bits      [3];
    int          phase     [3];
    int          abort_len [3];
    bit          abort_exp [3];
    bit          hold_err  [3];
    logic        bitval    [3];
    logic [10:0] cap       [3];
    logic [2:0]  tx_v, busy_v;
    logic        mt, mb;
    logic [10:0] exp_frame;

    assign tx_v   = {tx2, tx1, tx0};
    assign busy_v = {busy2, busy1, busy0};

    uart_tx_module #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_ODD(0)) dut_even (
        .clk(clk), .reset(reset), .enable(en0), .data_in(d0), .tx(tx0), .busy(busy0));
    uart_tx_module #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .reset(reset), .enable(en1), .data_in(d1), .tx(tx1), .busy(busy1));
    uart_tx_module #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_ODD(0)) dut_slow (
        .clk(clk), .reset(reset), .enable(en2), .data_in(d2), .tx(tx2), .busy(busy2));

    always #5 clk = ~clk;

    function automatic int qsize(input int id);
        case (id)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic pop_exp(input int id, output logic [10:0] v);
        v = 'x;
        case (id)
            0:       if (q0.size() != 0) v = q0.pop_front();
            1:       if (q1.size() != 0) v = q1.pop_front();
            default: if (q2.size() != 0) v = q2.pop_front();
        endcase
    endtask

    // Monitor: sample outputs on the falling edge, rebuild frames, compare against the queue
    always @(negedge clk) begin
        if (mon_on) begin
            for (int i = 0; i < 3; i++) begin
                mt = tx_v[i];
                mb = busy_v[i];
                if (mb === 1'b1) begin
                    if (bits[i] == 0 && phase[i] == 0) begin
                        nvec++;
                        if (qsize(i) == 0 && !abort_exp[i]) begin
                            nfail++;
                            $display("FAIL dut%0d unexpected_busy: busy=%b with no frame queued", i, mb);
                        end
                    end
                    if (phase[i] == 0) begin
                        bitval[i]   = mt;
                        hold_err[i] = 1'b0;
                    end else if (mt !== bitval[i]) begin
                        hold_err[i] = 1'b1;
                    end
                    phase[i]++;
                    if (phase[i] == cpb[i]) begin
                        phase[i] = 0;
                        nvec++;
                        if (hold_err[i]) begin
                            nfail++;
                            $display("FAIL dut%0d bit_hold: bit %0d changed within its %0d-cycle period (first=%b)",
                                     i, bits[i], cpb[i], bitval[i]);
                        end
                        cap[i] = {bitval[i], cap[i][10:1]};
                        bits[i]++;
                        if (bits[i] == 11) begin
                            bits[i] = 0;
                            pop_exp(i, exp_frame);
                            nvec++;
                            if (cap[i] !== exp_frame) begin
                                nfail++;
                                $display("FAIL dut%0d frame: got %b want %b", i, cap[i], exp_frame);
                            end
                        end
                    end
                end else begin
                    nvec++;
                    if (mt !== 1'b1 || mb !== 1'b0) begin
                        nfail++;
                        $display("FAIL dut%0d idle_line: tx=%b busy=%b want tx=1 busy=0", i, mt, mb);
                    end
                    if (bits[i] != 0 || phase[i] != 0) begin
                        nvec++;
                        if (!abort_exp[i]) begin
                            nfail++;
                            $display("FAIL dut%0d truncated_frame: busy fell after %0d cycles, want 0 or full frame",
                                     i, bits[i] * cpb[i] + phase[i]);
                        end else if (bits[i] * cpb[i] + phase[i] != abort_len[i]) begin
                            nfail++;
                            $display("FAIL dut%0d abort_len: got %0d busy cycles want %0d",
                                     i, bits[i] * cpb[i] + phase[i], abort_len[i]);
                        end
                        abort_exp[i] = 1'b0;
                        bits[i]      = 0;
                        phase[i]     = 0;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            bits[i] = 0; phase[i] = 0; abort_len[i] = 0; abort_exp[i] = 1'b0;
            hold_err[i] = 1'b0; bitval[i] = 1'b1; cap[i] = '0;
        end
        reset = 1'b1;
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
        d0 = 8'h00; d1 = 8'h00; d2 = 8'h00;
        tick(1);
        reset  = 1'b0;
        mon_on = 1'b1;
        tick(20);

        // All-zeros frame, even parity 0
        d0 = 8'h00; en0 = 1'b1; q0.push_back(11'h400);
        tick(1);
        en0 = 1'b0;
        tick(14);

        // 0xA5: popcount 4 -> parity 0; data_in change after load must be ignored
        d0 = 8'hA5; en0 = 1'b1; q0.push_back(11'h54A);
        tick(1);
        en0 = 1'b0; d0 = 8'hFF;
        tick(14);

        // 0x01: even parity 1 on dut_even, odd parity 0 on dut_odd
        d0 = 8'h01; en0 = 1'b1; q0.push_back(11'h602);
        d1 = 8'h01; en1 = 1'b1; q1.push_back(11'h402);
        tick(1);
        en0 = 1'b0; en1 = 1'b0;
        tick(14);

        // Back-to-back: 0x00 then 0xFF (parity 0) changed mid-frame, enable held through edge 12
        d0 = 8'h00; en0 = 1'b1; q0.push_back(11'h400);
        tick(5);
        d0 = 8'hFF; q0.push_back(11'h5FE);
        tick(7);
        en0 = 1'b0;
        tick(14);

        // Reset on edge 5 of a frame: four busy cycles, then idle with no restart
        abort_exp[0] = 1'b1; abort_len[0] = 4;
        d0 = 8'h3C; en0 = 1'b1;
        tick(1);
        en0 = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(6);

        // Fresh frame after the abort: 0xC3, popcount 4 -> parity 0
        d0 = 8'hC3; en0 = 1'b1; q0.push_back(11'h586);
        tick(1);
        en0 = 1'b0;
        tick(14);

        // Four clocks per bit: 44 busy cycles, each bit constant for 4 samples
        d2 = 8'hA5; en2 = 1'b1; q2.push_back(11'h54A);
        tick(1);
        en2 = 1'b0; d2 = 8'h00;
        tick(50);

        mon_on = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (qsize(i) != 0) begin
                nfail++;
                $display("FAIL dut%0d leftover: %0d frames never seen, want 0", i, qsize(i));
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
